// File: rtl/conv_window_scheduler_if.sv
// Result stream from the convolution window scheduler to the layer output writer.
// Each beat carries one MAC result tagged with its output row/column.
interface conv_window_scheduler_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
);
   logic              valid;
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] row;
   logic [ADDR_W-1:0] col;
   logic              ready;

   modport master (output valid, data, row, col, input ready);
   modport slave  (input valid, data, row, col, output ready);
endinterface

// File: rtl/conv_window_scheduler.sv
// Sequences one MAC over a stride-1, no-padding 2-D convolution, one window in flight,
// streaming each window's feature/weight pairs and forwarding the tagged results.
module conv_window_scheduler #(
   parameter int IMG_W                 = 8,
   parameter int IMG_H                 = 8,
   parameter int KERNEL_SIZE_W         = 3,
   parameter int KERNEL_SIZE_H         = 3,
   parameter int INPUT_BIT_RESOLUTION  = 8,
   parameter int OUTPUT_BIT_RESOLUTION = 32,
   parameter int ADDR_W                = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             start_i,
   output logic                             busy_o,
   output logic                             done_o,
   output logic [ADDR_W-1:0]                feat_addr_o,
   input  logic [INPUT_BIT_RESOLUTION-1:0]  feat_data_i,
   output logic [ADDR_W-1:0]                kern_addr_o,
   input  logic [INPUT_BIT_RESOLUTION-1:0]  kern_data_i,
   input  logic [OUTPUT_BIT_RESOLUTION-1:0] kernel_bias_i,
   output logic                             mac_in_valid_o,
   output logic [INPUT_BIT_RESOLUTION-1:0]  mac_feature_o,
   output logic [INPUT_BIT_RESOLUTION-1:0]  mac_weight_o,
   output logic [OUTPUT_BIT_RESOLUTION-1:0] mac_bias_o,
   input  logic                             mac_valid_i,
   input  logic [OUTPUT_BIT_RESOLUTION-1:0] mac_data_i,
   output logic                             mac_ready_o,
   conv_window_scheduler_if.master          out_if
);
   localparam int OUT_W = IMG_W - KERNEL_SIZE_W + 1;
   localparam int OUT_H = IMG_H - KERNEL_SIZE_H + 1;
   localparam int K     = KERNEL_SIZE_W * KERNEL_SIZE_H;

   localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(K - 1);
   localparam logic [ADDR_W-1:0] KW_LAST  = ADDR_W'(KERNEL_SIZE_W - 1);
   localparam logic [ADDR_W-1:0] OW_LAST  = ADDR_W'(OUT_W - 1);
   localparam logic [ADDR_W-1:0] OH_LAST  = ADDR_W'(OUT_H - 1);

   typedef enum logic [2:0] {IDLE, FEED, DRAIN, WAIT_MAC, OUTPUT} state_e;

   state_e                           state_q, state_d;
   logic [ADDR_W-1:0]                row_q, row_d, col_q, col_d;
   logic [ADDR_W-1:0]                kx_q, kx_d, ky_q, ky_d, k_q, k_d;
   logic [ADDR_W-1:0]                feat_addr_q, feat_addr_d, kern_addr_q, kern_addr_d;
   logic [ADDR_W-1:0]                out_row_q, out_row_d, out_col_q, out_col_d;
   logic [OUTPUT_BIT_RESOLUTION-1:0] bias_q, bias_d, out_data_q, out_data_d;
   logic                             busy_q, busy_d, done_q, done_d;
   logic                             mac_in_valid_q, mac_in_valid_d;
   logic                             mac_ready_q, mac_ready_d, out_valid_q, out_valid_d;

   function automatic logic [ADDR_W-1:0] window_addr(input logic [ADDR_W-1:0] r,
                                                     input logic [ADDR_W-1:0] c,
                                                     input logic [ADDR_W-1:0] x,
                                                     input logic [ADDR_W-1:0] y);
      return (r + y) * IMG_W_A + c + x;
   endfunction

   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      col_d          = col_q;
      kx_d           = kx_q;
      ky_d           = ky_q;
      k_d            = k_q;
      feat_addr_d    = feat_addr_q;
      kern_addr_d    = kern_addr_q;
      out_row_d      = out_row_q;
      out_col_d      = out_col_q;
      out_data_d     = out_data_q;
      bias_d         = bias_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      mac_ready_d    = mac_ready_q;
      out_valid_d    = out_valid_q;
      // Memory data lags the address by one cycle, so the MAC valid lags FEED by one.
      mac_in_valid_d = (state_q == FEED);

      case (state_q)
         IDLE: begin
            if (start_i && !done_q) begin
               state_d     = FEED;
               busy_d      = 1'b1;
               bias_d      = kernel_bias_i;
               row_d       = '0;
               col_d       = '0;
               kx_d        = '0;
               ky_d        = '0;
               k_d         = '0;
               feat_addr_d = '0;
               kern_addr_d = '0;
            end
         end
         FEED: begin
            if (k_q == K_LAST) begin
               state_d = DRAIN;
            end else begin
               k_d = k_q + 1'b1;
               if (kx_q == KW_LAST) begin
                  kx_d = '0;
                  ky_d = ky_q + 1'b1;
               end else begin
                  kx_d = kx_q + 1'b1;
               end
               feat_addr_d = window_addr(row_q, col_q, kx_d, ky_d);
               kern_addr_d = k_d;
            end
         end
         DRAIN: begin
            state_d     = WAIT_MAC;
            mac_ready_d = 1'b1;
         end
         WAIT_MAC: begin
            if (mac_valid_i) begin
               state_d     = OUTPUT;
               mac_ready_d = 1'b0;
               out_valid_d = 1'b1;
               out_data_d  = mac_data_i;
               out_row_d   = row_q;
               out_col_d   = col_q;
            end
         end
         OUTPUT: begin
            if (out_if.ready) begin
               out_valid_d = 1'b0;
               if (row_q == OH_LAST && col_q == OW_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  if (col_q == OW_LAST) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
                  state_d     = FEED;
                  kx_d        = '0;
                  ky_d        = '0;
                  k_d         = '0;
                  feat_addr_d = window_addr(row_d, col_d, '0, '0);
                  kern_addr_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         row_q          <= '0;
         col_q          <= '0;
         kx_q           <= '0;
         ky_q           <= '0;
         k_q            <= '0;
         feat_addr_q    <= '0;
         kern_addr_q    <= '0;
         out_row_q      <= '0;
         out_col_q      <= '0;
         out_data_q     <= '0;
         bias_q         <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         mac_in_valid_q <= 1'b0;
         mac_ready_q    <= 1'b0;
         out_valid_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         col_q          <= col_d;
         kx_q           <= kx_d;
         ky_q           <= ky_d;
         k_q            <= k_d;
         feat_addr_q    <= feat_addr_d;
         kern_addr_q    <= kern_addr_d;
         out_row_q      <= out_row_d;
         out_col_q      <= out_col_d;
         out_data_q     <= out_data_d;
         bias_q         <= bias_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         mac_in_valid_q <= mac_in_valid_d;
         mac_ready_q    <= mac_ready_d;
         out_valid_q    <= out_valid_d;
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign feat_addr_o    = feat_addr_q;
   assign kern_addr_o    = kern_addr_q;
   assign mac_in_valid_o = mac_in_valid_q;
   assign mac_feature_o  = mac_in_valid_q ? feat_data_i : '0;
   assign mac_weight_o   = mac_in_valid_q ? kern_data_i : '0;
   assign mac_bias_o     = bias_q;
   assign mac_ready_o    = mac_ready_q;
   assign out_if.valid   = out_valid_q;
   assign out_if.data    = out_data_q;
   assign out_if.row     = out_row_q;
   assign out_if.col     = out_col_q;
endmodule
